cd_export_arbiter: RTL

// Shares one outbound clock-domain-crossing channel (toggle req/ack, data held stable) among

---
 rtl/cd_export_arbiter_if.sv | 36 +++
 rtl/cd_export_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/cd_export_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : cd_export_arbiter_if
// Brief    : Requester handshake plus outbound toggle req/ack channel bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cd_export_arbiter_if #(
   parameter int pBits  = 8,
   parameter int pPorts = 4
);
   localparam int IDXW = (pPorts > 1) ? $clog2(pPorts) : 1;

   logic [pPorts-1:0]       in_valid;
   logic [pPorts-1:0]       in_ready;
   logic [pPorts*pBits-1:0] in_data;
   logic                    cd_req;
   logic [IDXW+pBits-1:0]   cd_data;
   logic                    cd_ack;
   logic                    busy;
   logic [IDXW-1:0]         grant_idx;

   // Arbiter side
   modport slave (
      input  in_valid, in_data, cd_ack,
      output in_ready, cd_req, cd_data, busy, grant_idx
   );

   // Requesters plus remote importer side
   modport master (
      output in_valid, in_data, cd_ack,
      input  in_ready, cd_req, cd_data, busy, grant_idx
   );
endinterface

`default_nettype wire

// File: rtl/cd_export_arbiter.sv
//------------------------------------------------------------------------------
// Module   : cd_export_arbiter
// Brief    : Round-robin arbiter sharing one toggle req/ack CDC export channel.
//            Define CD_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cd_export_arbiter #(
   parameter int pBits  = 8,
   parameter int pPorts = 4
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   cd_export_arbiter_if.slave bus
);
   localparam int IDXW = (pPorts > 1) ? $clog2(pPorts) : 1;

   localparam logic [IDXW:0]   c_ports = (IDXW+1)'(pPorts);
   localparam logic [IDXW-1:0] c_last  = IDXW'(pPorts - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t                r_state;
   logic                  r_ack_meta;
   logic                  r_ack_sync;
   logic                  r_cd_req;
   logic [IDXW+pBits-1:0] r_cd_data;
   logic [IDXW-1:0]       r_grant_idx;
   logic [IDXW-1:0]       r_ptr;
   logic                  r_busy;

   logic                  w_found;
   logic [IDXW-1:0]       w_winner;
   logic [IDXW:0]         w_sum;
   logic [IDXW-1:0]       w_idx;
   logic [IDXW-1:0]       w_next_ptr;
   logic [pPorts-1:0]     w_ready;

   // Scan from the pointer upward; descending loop so the nearest hit wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      w_idx    = '0;
      for (int k = pPorts - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_ptr} + (IDXW+1)'(k);
         if (w_sum >= c_ports) begin
            w_sum = w_sum - c_ports;
         end
         w_idx = w_sum[IDXW-1:0];
         if (bus.in_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   assign w_next_ptr = (w_winner == c_last) ? '0 : w_winner + 1'b1;

   // Grant is gated by rst_n so it drops the instant reset asserts.
   for (genvar gi = 0; gi < pPorts; gi++) begin : g_ready
      assign w_ready[gi] = rst_n && (r_state == ST_IDLE) && w_found &&
                           (w_winner == IDXW'(gi));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ack_meta  <= 1'b0;
         r_ack_sync  <= 1'b0;
         r_cd_req    <= 1'b0;
         r_cd_data   <= '0;
         r_grant_idx <= '0;
         r_ptr       <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_ack_meta <= bus.cd_ack;
         r_ack_sync <= r_ack_meta;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_cd_data   <= {w_winner, bus.in_data[w_winner*pBits +: pBits]};
                  r_cd_req    <= ~r_cd_req;
                  r_grant_idx <= w_winner;
`ifdef CD_ARB_FIXED_PRIO_EN
                  r_ptr       <= '0;
`else
                  r_ptr       <= w_next_ptr;
`endif
                  r_busy      <= 1'b1;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_ack_sync == r_cd_req) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.cd_req    = r_cd_req;
   assign bus.cd_data   = r_cd_data;
   assign bus.busy      = r_busy;
   assign bus.grant_idx = r_grant_idx;

endmodule

`default_nettype wire
